instr_reader: RTL and testbench

Read-side companion to the instruction register. Once started, it walks `read_pointer` through a window of register entries and captures each `instruction_word`. It executes the opcode on the two operands and presents every result on a valid/ready output stream. It sits between the instruction register's read port and the result checker or scoreboard.

---
 rtl/instr_register_pkg.sv | 34 +++
 rtl/instr_alu.sv | 53 +++++
 rtl/instr_reader.sv | 129 ++++++++++++
 tb/tb_instr_reader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side companion (instr_reader).
package instr_register_pkg;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HOLD  = 2'd3
    } reader_state_t;

    localparam int ADDR_W = $bits(address_t);
    localparam int OPND_W = $bits(operand_t);

endpackage

// File: rtl/instr_alu.sv
// Combinational executor for one instruction word.
// INSTR_READER_DIVMOD_EN enables the divider; without it DIV/MOD report an error.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int RES_WIDTH = 64
) (
    input  instruction_t                  instr,
    output logic signed [RES_WIDTH-1:0]   result,
    output logic                          err
);

    logic signed [RES_WIDTH-1:0] a_ext;
    logic signed [RES_WIDTH-1:0] b_ext;

    // Operands are widened first so MULT yields the full product and
    // the most-negative / -1 quotient does not overflow.
    always_comb begin
        a_ext = {{(RES_WIDTH-OPND_W){instr.op_a[OPND_W-1]}}, instr.op_a};
        b_ext = {{(RES_WIDTH-OPND_W){instr.op_b[OPND_W-1]}}, instr.op_b};
    end

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (instr.opc)
            ZERO:  result = '0;
            PASSA: result = a_ext;
            PASSB: result = b_ext;
            ADD:   result = a_ext + b_ext;
            SUB:   result = a_ext - b_ext;
            MULT:  result = a_ext * b_ext;
`ifdef INSTR_READER_DIVMOD_EN
            DIV: begin
                if (b_ext == '0) err = 1'b1;
                else             result = a_ext / b_ext;
            end
            MOD: begin
                if (b_ext == '0) err = 1'b1;
                else             result = a_ext % b_ext;
            end
`else
            DIV:   err = 1'b1;
            MOD:   err = 1'b1;
`endif
            default: begin
                result = '0;
                err    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_reader.sv
// Walks read_pointer over a window of instruction-register entries, executes each
// word and streams results out on valid/ready. Optional divider: INSTR_READER_DIVMOD_EN.
module instr_reader
    import instr_register_pkg::*;
#(
    parameter int NUM_ENTRIES = 32,
    parameter int RES_WIDTH   = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  address_t                    start_ptr,
    input  logic [ADDR_W:0]             num_instr,
    output address_t                    read_pointer,
    input  instruction_t                instruction_word,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic signed [RES_WIDTH-1:0] result,
    output opcode_t                     res_opcode,
    output address_t                    res_index,
    output logic                        res_err,
    output logic                        busy,
    output logic                        done
);

    reader_state_t               state;
    reader_state_t               state_next;
    logic [ADDR_W:0]             remaining;
    instruction_t                iw_q;

    logic                        load;
    logic                        capture;
    logic                        exec_en;
    logic                        accept;
    logic                        last;
    logic                        zero_done;
    address_t                    next_ptr;

    logic signed [RES_WIDTH-1:0] alu_result;
    logic                        alu_err;

    instr_alu #(
        .RES_WIDTH (RES_WIDTH)
    ) u_alu (
        .instr  (iw_q),
        .result (alu_result),
        .err    (alu_err)
    );

    assign last     = (remaining == (ADDR_W+1)'(1));
    assign next_ptr = (read_pointer == address_t'(NUM_ENTRIES-1)) ? '0 : read_pointer + 1'b1;
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        exec_en    = 1'b0;
        accept     = 1'b0;
        zero_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_instr != '0) begin
                        load       = 1'b1;
                        state_next = FETCH;
                    end else begin
                        zero_done  = 1'b1;
                    end
                end
            end
            FETCH: begin
                capture    = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                exec_en    = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (res_valid && res_ready) begin
                    accept     = 1'b1;
                    state_next = last ? IDLE : FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control and presented outputs; reset drops any in-flight result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            read_pointer <= '0;
            remaining    <= '0;
            res_valid    <= 1'b0;
            result       <= '0;
            res_opcode   <= ZERO;
            res_index    <= '0;
            res_err      <= 1'b0;
            done         <= 1'b0;
        end else begin
            state <= state_next;
            done  <= zero_done | (accept & last);
            if (load) begin
                read_pointer <= start_ptr;
                remaining    <= num_instr;
            end
            if (exec_en) begin
                result     <= alu_result;
                res_opcode <= iw_q.opc;
                res_index  <= read_pointer;
                res_err    <= alu_err;
                res_valid  <= 1'b1;
            end
            if (accept) begin
                remaining <= remaining - 1'b1;
                res_valid <= 1'b0;
                if (!last) read_pointer <= next_ptr;
            end
        end
    end

    // Fetched word is pure data; it is only consumed after a fresh capture.
    always_ff @(posedge clk) begin
        if (capture) iw_q <= instruction_word;
    end

endmodule

// File: tb/tb_instr_reader.sv
// Directed self-checking bench for instr_reader with a behavioural instruction register.
module tb_instr_reader;
    import instr_register_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    address_t           start_ptr = '0;
    logic [ADDR_W:0]    num_instr = '0;
    address_t           read_pointer;
    instruction_t       instruction_word;
    logic               res_valid;
    logic               res_ready = 1'b1;
    logic signed [63:0] result;
    opcode_t            res_opcode;
    address_t           res_index;
    logic               res_err;
    logic               busy;
    logic               done;

    instruction_t mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    longint got_res [$];
    int     got_idx [$];
    int     got_err [$];
    int     got_cyc [$];

    always #5 clk = ~clk;

    assign instruction_word = mem[read_pointer];

    instr_reader #(
        .NUM_ENTRIES (32),
        .RES_WIDTH   (64)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_ptr        (start_ptr),
        .num_instr        (num_instr),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .result           (result),
        .res_opcode       (res_opcode),
        .res_index        (res_index),
        .res_err          (res_err),
        .busy             (busy),
        .done             (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    function automatic instruction_t mk(input opcode_t o, input int a, input int b);
        instruction_t w;
        w.opc  = o;
        w.op_a = a;
        w.op_b = b;
        return w;
    endfunction

    // Leaves the bench at the falling edge just after the start edge.
    task automatic pulse_start(input address_t p, input int n);
        @(negedge clk);
        start     = 1'b1;
        start_ptr = p;
        num_instr = (ADDR_W+1)'(n);
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic collect(input int budget);
        int cyc;
        cyc = 0;
        got_res.delete();
        got_idx.delete();
        got_err.delete();
        got_cyc.delete();
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (res_valid && res_ready) begin
                got_res.push_back(result);
                got_idx.push_back(int'(res_index));
                got_err.push_back(int'(res_err));
                got_cyc.push_back(cyc);
            end
        end
        check("run_done_within_budget", done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint exp_res [8];
        int     exp_err [8];

        for (int i = 0; i < 32; i++) mem[i] = '0;

        // Reset state
        #3;
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ptr", read_pointer, 0);
        check("rst_result", result, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single ADD with exact latency
        mem[3]    = mk(ADD, 7, -2);
        res_ready = 1'b1;
        pulse_start(5'd3, 1);
        check("add_ptr", read_pointer, 3);
        check("add_busy", busy, 1);
        check("add_valid_n", res_valid, 0);
        @(negedge clk);
        check("add_valid_n1", res_valid, 0);
        @(negedge clk);
        check("add_valid_n2", res_valid, 1);
        check("add_result", result, 5);
        check("add_index", res_index, 3);
        check("add_opcode", res_opcode, ADD);
        check("add_err", res_err, 0);
        check("add_done_early", done, 0);
        @(negedge clk);
        check("add_valid_after", res_valid, 0);
        check("add_done", done, 1);
        check("add_busy_end", busy, 0);
        @(negedge clk);
        check("add_done_pulse", done, 0);

        // Every opcode, a=-9 b=4
        for (int i = 0; i < 8; i++) mem[i] = mk(opcode_t'(i), -9, 4);
        exp_res = '{0, -9, 4, -5, -13, -36, -2, -1};
        exp_err = '{0, 0, 0, 0, 0, 0, 0, 0};
`ifndef INSTR_READER_DIVMOD_EN
        exp_res[6] = 0; exp_res[7] = 0;
        exp_err[6] = 1; exp_err[7] = 1;
`endif
        pulse_start(5'd0, 8);
        collect(100);
        check("opc_count", got_res.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_res.size()) begin
                check($sformatf("opc%0d_result", i), got_res[i], exp_res[i]);
                check($sformatf("opc%0d_err", i), got_err[i], exp_err[i]);
                check($sformatf("opc%0d_index", i), got_idx[i], i);
                if (i > 0) check($sformatf("opc%0d_spacing", i), got_cyc[i] - got_cyc[i-1], 3);
            end
        end

        // Backpressure
        mem[10]   = mk(SUB, 100, 1);
        mem[11]   = mk(MULT, -3, 5);
        res_ready = 1'b0;
        pulse_start(5'd10, 2);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", res_valid, 1);
            check("bp_result", result, 99);
            check("bp_index", res_index, 10);
            check("bp_ptr", read_pointer, 10);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_cleared", res_valid, 0);
        check("bp_ptr_adv", read_pointer, 11);
        @(negedge clk);
        @(negedge clk);
        check("bp_second_valid", res_valid, 1);
        check("bp_second_result", result, -15);
        check("bp_second_index", res_index, 11);
        @(negedge clk);
        check("bp_done", done, 1);

        // Pointer wrap
        mem[30] = mk(PASSA, 30, 0);
        mem[31] = mk(PASSB, 0, 31);
        pulse_start(5'd30, 4);
        collect(100);
        check("wrap_count", got_res.size(), 4);
        if (got_idx.size() == 4) begin
            check("wrap_idx0", got_idx[0], 30);
            check("wrap_idx1", got_idx[1], 31);
            check("wrap_idx2", got_idx[2], 0);
            check("wrap_idx3", got_idx[3], 1);
            check("wrap_res1", got_res[1], 31);
            check("wrap_res3", got_res[3], -9);
        end

        // Zero count
        pulse_start(5'd7, 0);
        check("zero_done", done, 1);
        check("zero_valid", res_valid, 0);
        check("zero_busy", busy, 0);
        @(negedge clk);
        check("zero_done_pulse", done, 0);
        check("zero_valid_later", res_valid, 0);

        // Divide by zero and disabled divider
        mem[5] = mk(DIV, 10, 0);
        mem[6] = mk(DIV, 10, 2);
        mem[7] = mk(MOD, 10, 0);
        pulse_start(5'd5, 3);
        collect(100);
        check("div_count", got_res.size(), 3);
        if (got_res.size() == 3) begin
            check("div0_result", got_res[0], 0);
            check("div0_err", got_err[0], 1);
`ifdef INSTR_READER_DIVMOD_EN
            check("div_ok_result", got_res[1], 5);
            check("div_ok_err", got_err[1], 0);
`else
            check("div_off_result", got_res[1], 0);
            check("div_off_err", got_err[1], 1);
`endif
            check("mod0_result", got_res[2], 0);
            check("mod0_err", got_err[2], 1);
        end

        // Asynchronous reset while holding a result
        mem[12]   = mk(ADD, 1, 2);
        res_ready = 1'b0;
        pulse_start(5'd12, 1);
        @(negedge clk);
        @(negedge clk);
        check("mid_valid_before", res_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_valid", res_valid, 0);
        check("mid_result", result, 0);
        check("mid_ptr", read_pointer, 0);
        check("mid_index", res_index, 0);
        check("mid_opcode", res_opcode, ZERO);
        check("mid_err", res_err, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        res_ready = 1'b1;
        pulse_start(5'd12, 1);
        collect(100);
        check("post_rst_count", got_res.size(), 1);
        if (got_res.size() == 1) begin
            check("post_rst_result", got_res[0], 3);
            check("post_rst_index", got_idx[0], 12);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
